if_fetch_unit: RTL and testbench

//  Instruction-fetch front end: producer side of the IF/ID pipeline register. Generates sequential/redirected PCs,

---
 rtl/cpu_pkg.sv | 14 +
 rtl/if_inst_buf.sv | 39 +++
 rtl/if_fetch_unit.sv | 112 +++++++++++
 tb/tb_if_fetch_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch front end.
// Imported by the IF stage and its instruction buffer.
package cpu_pkg;

   localparam logic [31:0] INST_RESET = 32'h0000_0000;
   localparam int          PC_STEP    = 4;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } fetch_state_e;

endpackage

// File: rtl/if_inst_buf.sv
// One-entry {pc, inst} holding register between memory response and IF/ID.
// Contents persist after a read so the outputs hold their last value.
module if_inst_buf
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_pc,
   input  logic [31:0]       wr_inst,
   input  logic              rd_en,
   input  logic              flush,
   output logic              valid,
   output logic [ADDR_W-1:0] rd_pc,
   output logic [31:0]       rd_inst
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid   <= 1'b0;
         rd_pc   <= '0;
         rd_inst <= INST_RESET;
      end else begin
         if (wr_en) begin
            rd_pc   <= wr_pc;
            rd_inst <= wr_inst;
         end
         if (flush)
            valid <= 1'b0;
         else if (wr_en)
            valid <= 1'b1;
         else if (rd_en)
            valid <= 1'b0;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC generation, single-outstanding memory handshake,
// redirect handling and the one-entry buffer feeding IF/ID.
module if_fetch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              wfi_hold,
   output logic              im_req,
   output logic [ADDR_W-1:0] im_addr,
   input  logic              im_ready,
   input  logic              im_rvalid,
   input  logic [31:0]       im_rdata,
   output logic [ADDR_W-1:0] pc,
   output logic [31:0]       inst,
   output logic              stall_IF
);

   fetch_state_e      state;
   fetch_state_e      state_nxt;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] req_pc;
   logic [ADDR_W-1:0] redirect_tgt;
   logic              drop;
   logic              buf_valid;
   logic              consume;
   logic              issue;
   logic              accept;
   logic              rsp;
   logic              wr_en;

   assign redirect_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};
   assign consume      = buf_valid & ~stall & ~redirect_valid;
   assign rsp          = im_rvalid & (state == WAIT);
   assign wr_en        = rsp & ~drop & ~redirect_valid;
   assign stall_IF     = ~buf_valid & ~redirect_valid;

   // A pending REQ keeps its address even if a redirect lands meanwhile
   always_comb begin
      issue     = 1'b0;
      im_req    = 1'b0;
      im_addr   = fetch_pc;
      state_nxt = state;
      unique case (state)
         IDLE: begin
            issue = ~rst & ~wfi_hold & ~redirect_valid
                  & (~buf_valid | consume);
            im_req = issue;
            if (issue)
               state_nxt = im_ready ? WAIT : REQ;
         end
         REQ: begin
            im_req  = 1'b1;
            im_addr = req_pc;
            if (im_ready)
               state_nxt = WAIT;
         end
         WAIT: begin
            if (im_rvalid)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept = im_req & im_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         req_pc   <= RESET_PC;
         drop     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (issue)
            req_pc <= fetch_pc;
         if (redirect_valid)
            fetch_pc <= redirect_tgt;
         else if (accept & ~drop)
            fetch_pc <= im_addr + ADDR_W'(PC_STEP);
         // Stale response still owed unless it is arriving right now
         if (redirect_valid &&
             (state == REQ || (state == WAIT && !im_rvalid)))
            drop <= 1'b1;
         else if (rsp)
            drop <= 1'b0;
      end
   end

   if_inst_buf #(
      .ADDR_W (ADDR_W)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_pc   (req_pc),
      .wr_inst (im_rdata),
      .rd_en   (consume),
      .flush   (redirect_valid),
      .valid   (buf_valid),
      .rd_pc   (pc),
      .rd_inst (inst)
   );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: stream, stall, redirects,
// memory backpressure, wfi, address wrap and mid-transaction reset.
module tb_if_fetch_unit;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        wfi_hold;
   logic        im_req;
   logic [31:0] im_addr;
   logic        im_ready;
   logic        im_rvalid;
   logic [31:0] im_rdata;
   logic [31:0] pc;
   logic [31:0] inst;
   logic        stall_IF;

   int n_chk;
   int n_fail;

   if_fetch_unit #(
      .ADDR_W   (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .wfi_hold       (wfi_hold),
      .im_req         (im_req),
      .im_addr        (im_addr),
      .im_ready       (im_ready),
      .im_rvalid      (im_rvalid),
      .im_rdata       (im_rdata),
      .pc             (pc),
      .inst           (inst),
      .stall_IF       (stall_IF)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk          = 0;
      n_fail         = 0;
      rst            = 1'b1;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      wfi_hold       = 1'b0;
      im_ready       = 1'b0;
      im_rvalid      = 1'b0;
      im_rdata       = 32'h0;
      #2;
      chk("rst_req", {31'b0, im_req}, 32'h0);
      chk("rst_addr", im_addr, 32'h0);
      chk("rst_stallif", {31'b0, stall_IF}, 32'h1);
      chk("rst_pc", pc, 32'h0);
      chk("rst_inst", inst, 32'h0);

      // sequential stream
      nxt();
      rst = 1'b0; im_ready = 1'b1; #1;
      chk("c1_req", {31'b0, im_req}, 32'h1);
      chk("c1_addr", im_addr, 32'h0);
      nxt();
      im_rvalid = 1'b1; im_rdata = 32'hC0DE_0000; #1;
      chk("c2_req", {31'b0, im_req}, 32'h0);
      chk("c2_stallif", {31'b0, stall_IF}, 32'h1);
      nxt();
      im_rvalid = 1'b0; #1;
      chk("c3_stallif", {31'b0, stall_IF}, 32'h0);
      chk("c3_pc", pc, 32'h0);
      chk("c3_inst", inst, 32'hC0DE_0000);
      chk("c3_req", {31'b0, im_req}, 32'h1);
      chk("c3_addr", im_addr, 32'h4);
      nxt();
      im_rvalid = 1'b1; im_rdata = 32'hC0DE_0004; #1;
      chk("c4_stallif", {31'b0, stall_IF}, 32'h1);

      // downstream stall with buffer full
      nxt();
      im_rvalid = 1'b0; stall = 1'b1; #1;
      chk("c5_pc", pc, 32'h4);
      chk("c5_inst", inst, 32'hC0DE_0004);
      chk("c5_stallif", {31'b0, stall_IF}, 32'h0);
      chk("c5_req", {31'b0, im_req}, 32'h0);
      nxt(); #1;
      chk("c6_req", {31'b0, im_req}, 32'h0);
      chk("c6_pc", pc, 32'h4);
      nxt(); #1;
      chk("c7_req", {31'b0, im_req}, 32'h0);
      chk("c7_inst", inst, 32'hC0DE_0004);
      nxt();
      stall = 1'b0; #1;
      chk("c8_req", {31'b0, im_req}, 32'h1);
      chk("c8_addr", im_addr, 32'h8);

      // redirect while waiting for 0x8
      nxt();
      redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
      chk("c9_stallif", {31'b0, stall_IF}, 32'h0);
      chk("c9_req", {31'b0, im_req}, 32'h0);
      nxt();
      redirect_valid = 1'b0;
      im_rvalid = 1'b1; im_rdata = 32'hC0DE_0008; #1;
      chk("c10_req", {31'b0, im_req}, 32'h0);
      chk("c10_stallif", {31'b0, stall_IF}, 32'h1);
      nxt();
      im_rvalid = 1'b0; #1;
      chk("c11_stallif", {31'b0, stall_IF}, 32'h1);
      chk("c11_req", {31'b0, im_req}, 32'h1);
      chk("c11_addr", im_addr, 32'h100);
      nxt();
      im_rvalid = 1'b1; im_rdata = 32'hC0DE_0100; #1;
      nxt();
      im_rvalid = 1'b0; #1;
      chk("c13_pc", pc, 32'h100);
      chk("c13_inst", inst, 32'hC0DE_0100);
      chk("c13_stallif", {31'b0, stall_IF}, 32'h0);
      chk("c13_addr", im_addr, 32'h104);

      // redirect to unaligned target with response same cycle
      nxt();
      redirect_valid = 1'b1; redirect_pc = 32'h203;
      im_rvalid = 1'b1; im_rdata = 32'hC0DE_0104; #1;
      chk("c14_stallif", {31'b0, stall_IF}, 32'h0);
      chk("c14_req", {31'b0, im_req}, 32'h0);

      // memory backpressure for 4 cycles
      nxt();
      redirect_valid = 1'b0; im_rvalid = 1'b0; im_ready = 1'b0; #1;
      chk("c15_stallif", {31'b0, stall_IF}, 32'h1);
      chk("c15_req", {31'b0, im_req}, 32'h1);
      chk("c15_addr", im_addr, 32'h200);
      for (int i = 0; i < 3; i++) begin
         nxt(); #1;
         chk("bp_req", {31'b0, im_req}, 32'h1);
         chk("bp_addr", im_addr, 32'h200);
         chk("bp_stallif", {31'b0, stall_IF}, 32'h1);
      end
      nxt();
      im_ready = 1'b1; #1;
      chk("c19_addr", im_addr, 32'h200);
      nxt();
      im_rvalid = 1'b1; im_rdata = 32'hC0DE_0200; #1;

      // wfi blocks new requests
      nxt();
      im_rvalid = 1'b0; wfi_hold = 1'b1; #1;
      chk("c21_pc", pc, 32'h200);
      chk("c21_inst", inst, 32'hC0DE_0200);
      chk("c21_req", {31'b0, im_req}, 32'h0);
      nxt(); #1;
      chk("c22_stallif", {31'b0, stall_IF}, 32'h1);
      chk("c22_req", {31'b0, im_req}, 32'h0);

      // address wrap at top of memory
      nxt();
      wfi_hold = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
      nxt();
      redirect_valid = 1'b0; #1;
      chk("c24_req", {31'b0, im_req}, 32'h1);
      chk("c24_addr", im_addr, 32'hFFFF_FFFC);
      nxt();
      im_rvalid = 1'b1; im_rdata = 32'hC0DE_FFFC; #1;
      nxt();
      im_rvalid = 1'b0; #1;
      chk("c26_pc", pc, 32'hFFFF_FFFC);
      chk("c26_inst", inst, 32'hC0DE_FFFC);
      chk("c26_addr", im_addr, 32'h0);
      chk("c26_req", {31'b0, im_req}, 32'h1);

      // reset pulse while waiting
      nxt();
      rst = 1'b1; #1;
      chk("c27_req", {31'b0, im_req}, 32'h0);
      chk("c27_stallif", {31'b0, stall_IF}, 32'h1);
      chk("c27_pc", pc, 32'h0);
      nxt();
      rst = 1'b0; #1;
      chk("c28_req", {31'b0, im_req}, 32'h1);
      chk("c28_addr", im_addr, 32'h0);
      chk("c28_stallif", {31'b0, stall_IF}, 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
